// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared widths and priority-encode helper for the switch encoders
package prio_enc_pkg;
  localparam int SW_W = 8;
  localparam int CODE_W = 3;
  function automatic logic [CODE_W:0] prio_enc(input logic [SW_W-1:0] v);
    logic [CODE_W:0] r;
    r = '0;
    for (int i = 0; i < SW_W; i++)
      if (v[i]) r = {1'b1, CODE_W'(i)};
    return r;
  endfunction
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchroniser plus whole-vector stability counter
module sw_debounce #(
  parameter int W = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [W-1:0] r_sync1, r_sync2, r_prev, r_stable;
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_prev   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= d;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_sync2 != r_prev || r_sync2 == r_stable) r_cnt <= '0;
      else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else r_cnt <= r_cnt + CNT_W'(1);
    end
  assign q = r_stable;
endmodule

// File: rtl/prio_encode_sampler.sv
// prio_encode_sampler: debounced 8-line switch sampler feeding a 3-bit priority code
module prio_encode_sampler
  import prio_enc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SW_W-1:0]   sw_in,
  input  logic              en,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              changed
);
  logic [SW_W-1:0] w_stable;
  logic [CODE_W:0] w_next;
  sw_debounce #(.W(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk), .rst_n(rst_n), .d(sw_in), .q(w_stable)
  );
  // prio_enc already yields all-zero for an empty vector, so valid=0 forces code=0
  always_comb w_next = en ? prio_enc(w_stable) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      code    <= '0;
      valid   <= 1'b0;
      changed <= 1'b0;
    end else begin
      {valid, code} <= w_next;
      changed       <= w_next != {valid, code};
    end
endmodule

// File: tb/tb_prio_encode_sampler.sv
// tb_prio_encode_sampler: directed-vector bench for the debounced priority sampler
module tb_prio_encode_sampler;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic [7:0] sw_in = 8'hFF;
  logic [2:0] code;
  logic valid, changed;
  logic [2:0] exp_code = '0;
  logic exp_valid = 1'b0;
  int n_cmp = 0, n_err = 0;

  prio_encode_sampler #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .en(en),
    .code(code), .valid(valid), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic edge_s();
    @(posedge clk);
    #1;
  endtask

  // apply v before edge 1; new outputs must appear exactly at edge 8, strobe at edge 8 only
  task automatic lat(input string tag, input logic [7:0] v, input logic [2:0] c, input logic vl);
    @(negedge clk);
    sw_in = v;
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      edge_s();
      if (e < 8) begin
        chk({tag, "_hold_code"}, 8'(code), 8'(exp_code));
        chk({tag, "_hold_valid"}, 8'(valid), 8'(exp_valid));
        chk({tag, "_hold_chg"}, 8'(changed), 8'(0));
      end else if (e == 8) begin
        chk({tag, "_code"}, 8'(code), 8'(c));
        chk({tag, "_valid"}, 8'(valid), 8'(vl));
        chk({tag, "_chg"}, 8'(changed), 8'(exp_code != c || exp_valid != vl));
      end else
        chk({tag, "_chg_off"}, 8'(changed), 8'(0));
    end
    exp_code = c;
    exp_valid = vl;
  endtask

  initial begin
    #1;
    chk("rst_code", 8'(code), 8'(0));
    chk("rst_valid", 8'(valid), 8'(0));
    chk("rst_chg", 8'(changed), 8'(0));
    for (int i = 0; i < 10; i++) edge_s();
    chk("rst_held_code", 8'(code), 8'(0));
    chk("rst_held_valid", 8'(valid), 8'(0));
    chk("rst_held_chg", 8'(changed), 8'(0));

    lat("ff_release", 8'hFF, 3'd7, 1'b1);
    lat("to_zero", 8'h00, 3'd0, 1'b0);
    lat("bit2", 8'h04, 3'd2, 1'b1);
    lat("multi", 8'h90, 3'd7, 1'b1);
    lat("clear", 8'h00, 3'd0, 1'b0);
    lat("lsb", 8'h01, 3'd0, 1'b1);

    // three-cycle glitch on bit 5 must never be accepted
    @(negedge clk);
    sw_in = 8'h21;
    repeat (3) @(negedge clk);
    sw_in = 8'h01;
    for (int i = 0; i < 12; i++) begin
      edge_s();
      chk("glitch_chg", 8'(changed), 8'(0));
      chk("glitch_code", 8'(code), 8'(0));
      chk("glitch_valid", 8'(valid), 8'(1));
    end

    lat("msb", 8'h80, 3'd7, 1'b1);
    @(negedge clk);
    en = 1'b0;
    edge_s();
    chk("en_off_valid", 8'(valid), 8'(0));
    chk("en_off_code", 8'(code), 8'(0));
    chk("en_off_chg", 8'(changed), 8'(1));
    edge_s();
    chk("en_off_chg_off", 8'(changed), 8'(0));
    @(negedge clk);
    en = 1'b1;
    edge_s();
    chk("en_on_code", 8'(code), 8'(7));
    chk("en_on_valid", 8'(valid), 8'(1));
    chk("en_on_chg", 8'(changed), 8'(1));
    edge_s();
    chk("en_on_chg_off", 8'(changed), 8'(0));

    // reset while the debounce counter sits at 2
    @(negedge clk);
    sw_in = 8'h08;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_code", 8'(code), 8'(0));
    chk("mid_rst_valid", 8'(valid), 8'(0));
    chk("mid_rst_chg", 8'(changed), 8'(0));
    exp_code = '0;
    exp_valid = 1'b0;
    repeat (2) @(posedge clk);
    lat("after_rst", 8'h08, 3'd3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
